pe_pipe: RTL



---
 rtl/pe_pipe_if.sv | 29 ++
 rtl/pe_pipe.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pe_pipe_if.sv
// pe_pipe_if: operand/result handshake bundle for one pe_pipe lane.
//   master : upstream/writeback side (drives operands and out_ready)
//   slave  : the processing element
// Signals: in_valid/in_ready + a, b, op (operand transfer);
//          out_valid/out_ready + c, ovf (result transfer).
interface pe_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_W       = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [OP_W-1:0]       op;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] c;
  logic                  ovf;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, c, ovf
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, c, ovf
  );
endinterface

// File: rtl/pe_pipe.sv
// pe_pipe: two-stage pipelined SIMD lane ALU with per-lane accumulator.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (drops in-flight ops, clears acc)
//   bus   : pe_pipe_if.slave -- operands a/b/op in, result c/ovf out,
//           valid/ready on both sides
// Ops: PASS ADD SUB MUL MAC MIN MAX CLR. S1 registers operands and the full
// signed product; S2 forms the full-precision result, narrows it and
// updates the accumulator (MAC/CLR only).
// Build option: define PE_SAT_EN to clamp overflowing ADD/SUB/MUL/MAC
// results; otherwise they wrap. ovf is the same in both builds.
module pe_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_W       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  pe_pipe_if.slave    bus
);

  localparam int DW     = DATA_WIDTH;
  localparam int PW     = 2 * DW;      // full product width
  localparam int FW     = 2 * DW + 1;  // full-precision result width
  localparam int STAGES = 2;

  localparam logic [OP_W-1:0] OP_PASS = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MAC  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MIN  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MAX  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_CLR  = OP_W'(7);

`ifdef PE_SAT_EN
  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
`endif

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [PW-1:0]   prod;
  } s1_t;

  // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied
  logic [STAGES:1] vld_pipe;
  logic            s1_adv;
  logic            in_xfer;

  s1_t             s1_q;
  s1_t             s1_d;
  logic [DW-1:0]   acc_q;
  logic [DW-1:0]   c_q;
  logic            ovf_q;

  // ---------------- handshake ----------------
  // S1 may move into S2 when S2 is empty or is being drained this cycle;
  // this is the only out_ready -> in_ready combinational path.
  assign s1_adv        = vld_pipe[1] && (!vld_pipe[2] || bus.out_ready);
  assign bus.in_ready  = !vld_pipe[1] || s1_adv;
  assign in_xfer       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld_pipe[2];
  assign bus.c         = c_q;
  assign bus.ovf       = ovf_q;

  // ---------------- stage 1 ----------------
  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;

  assign a_x = PW'($signed(bus.a));
  assign b_x = PW'($signed(bus.b));

  always_comb begin
    s1_d      = '0;
    s1_d.op   = bus.op;
    s1_d.a    = bus.a;
    s1_d.b    = bus.b;
    s1_d.prod = a_x * b_x;   // low PW bits of sign-extended operands = exact product
  end

  // ---------------- stage 2 ----------------
  logic signed [FW-1:0] a_f;
  logic signed [FW-1:0] b_f;
  logic signed [FW-1:0] p_f;
  logic signed [FW-1:0] acc_f;
  logic signed [FW-1:0] full;
  logic                 can_ovf;
  logic [DW+1:0]        hi;
  logic                 rng_ovf;
  logic [DW-1:0]        res;
  logic                 ovf_d;

  assign a_f   = FW'($signed(s1_q.a));
  assign b_f   = FW'($signed(s1_q.b));
  assign p_f   = FW'($signed(s1_q.prod));
  assign acc_f = FW'($signed(acc_q));

  // Every op is evaluated at FW bits; ADD/SUB only need DW+1 but the wider
  // sum is numerically identical and keeps a single range check.
  always_comb begin
    full    = '0;
    can_ovf = 1'b0;
    case (s1_q.op)
      OP_PASS: full = b_f;
      OP_ADD:  begin full = a_f + b_f;   can_ovf = 1'b1; end
      OP_SUB:  begin full = a_f - b_f;   can_ovf = 1'b1; end
      OP_MUL:  begin full = p_f;         can_ovf = 1'b1; end
      OP_MAC:  begin full = acc_f + p_f; can_ovf = 1'b1; end
      OP_MIN:  full = (a_f < b_f) ? a_f : b_f;
      OP_MAX:  full = (a_f > b_f) ? a_f : b_f;
      default: full = '0;              // CLR
    endcase
  end

  // In range iff every bit from the sign bit of the narrow result upward
  // agrees with it.
  assign hi      = full[FW-1:DW-1];
  assign rng_ovf = !((&hi) || !(|hi));
  assign ovf_d   = can_ovf && rng_ovf;

`ifdef PE_SAT_EN
  assign res = ovf_d ? (full[FW-1] ? SAT_MIN : SAT_MAX) : full[DW-1:0];
`else
  assign res = full[DW-1:0];
`endif

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      acc_q    <= '0;
      c_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (in_xfer)     vld_pipe[1] <= 1'b1;
      else if (s1_adv) vld_pipe[1] <= 1'b0;

      if (s1_adv)             vld_pipe[2] <= 1'b1;
      else if (bus.out_ready) vld_pipe[2] <= 1'b0;

      if (in_xfer) s1_q <= s1_d;

      // S2 (and acc) only move when S1 advances, so a stall freezes c/ovf/acc
      if (s1_adv) begin
        c_q   <= res;
        ovf_q <= ovf_d;
        if (s1_q.op == OP_MAC || s1_q.op == OP_CLR) acc_q <= res;
      end
    end
  end

endmodule
